// File: rtl/if_pkg.sv
// ----------------------------------------------------------------------------
// if_pkg
// Shared types and helpers for the instruction-fetch sequencer.
//   state_e        : sequencer state (IDLE / RUN / FAULT)
//   fetch_entry_t  : one buffered fetch result {pc, instr}
//   pcLegal()      : word-aligned and within the instruction memory
// ----------------------------------------------------------------------------
package if_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // lastWord is the highest legal word address (memory size minus 4).
    function automatic logic pcLegal(input logic [ADDR_W-1:0] pc,
                                     input logic [ADDR_W-1:0] lastWord);
        return (pc[1:0] == 2'b00) && (pc <= lastWord);
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// ----------------------------------------------------------------------------
// if_fetch_fifo
// Two-entry FIFO of fetch entries between the fetch sequencer and decode.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push_i          : write push_data_i (ignored when full without a pop)
//   push_data_i     : entry to write
//   pop_i           : consume the head (ignored when empty)
//   flush_i         : discard all entries; wins over push
//   count_o         : number of buffered entries (0..2)
//   head_o          : oldest entry
// ----------------------------------------------------------------------------
module if_fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         wrPtr_q, wrPtr_d;
    logic         rdPtr_q, rdPtr_d;
    logic [1:0]   count_q, count_d;
    logic         doPush;
    logic         doPop;

    // A pop frees a slot in the same cycle, so a full FIFO can push and pop
    // together and stay full.
    always_comb begin
        mem_d   = mem_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        doPop   = pop_i && (count_q != 2'd0);
        doPush  = push_i && ((count_q != FULL_COUNT) || doPop);

        if (flush_i) begin
            wrPtr_d = 1'b0;
            rdPtr_d = 1'b0;
            count_d = 2'd0;
        end else begin
            if (doPush) begin
                mem_d[wrPtr_q] = push_data_i;
                wrPtr_d        = ~wrPtr_q;
            end
            if (doPop) begin
                rdPtr_d = ~rdPtr_q;
            end
            count_d = count_q + {1'b0, doPush} - {1'b0, doPop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            mem_q   <= mem_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rdPtr_q];

endmodule

// File: rtl/if_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// if_fetch_ctrl
// Instruction-fetch sequencer. Owns the PC, presents it to a combinational
// instruction memory and buffers {pc, word} pairs in a 2-entry FIFO toward
// decode. Supports start, redirect with flush, and a sticky fault on
// misaligned or out-of-range PCs.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   start                    : IDLE -> RUN pulse
//   redirect_valid/_pc       : load new PC and flush the buffer
//   imem_addr / imem_rdata   : instruction memory address and returned word
//   out_valid/ready/instr/pc : handshake toward decode
//   fault, fault_pc          : sticky fault flag and offending PC
//   busy                     : high in RUN
// ----------------------------------------------------------------------------
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_BYTES  = 128,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [ADDR_W-1:0]   out_pc,
    output logic                fault,
    output logic [ADDR_W-1:0]   fault_pc,
    output logic                busy
);

    localparam logic [ADDR_W-1:0] LAST_WORD  = ADDR_W'(MEM_BYTES - 4);
    localparam logic [1:0]        FULL_COUNT = 2'(FIFO_DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] faultPc_q, faultPc_d;

    logic         fifoPush;
    logic         fifoFlush;
    logic         fifoPop;
    logic [1:0]   fifoCount;
    fetch_entry_t fifoHead;
    fetch_entry_t pushData;
    logic         outValid;

    assign outValid = (fifoCount != 2'd0);
    assign fifoPop  = outValid && out_ready;
    assign pushData = '{pc: pc_q, instr: imem_rdata};

    // Redirect overrides everything. A pop in the same cycle still counts as
    // accepted by decode; the flush then empties whatever is left. In RUN the
    // current PC is range-checked before any fetch so a bad PC never reaches
    // the buffer.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        faultPc_d = faultPc_q;
        fifoPush  = 1'b0;
        fifoFlush = 1'b0;

        if (redirect_valid) begin
            pc_d      = redirect_pc;
            fifoFlush = 1'b1;
            if (state_q == FAULT) begin
                if (pcLegal(redirect_pc, LAST_WORD)) begin
                    state_d = RUN;
                end else begin
                    faultPc_d = redirect_pc;
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!pcLegal(pc_q, LAST_WORD)) begin
                        state_d   = FAULT;
                        faultPc_d = pc_q;
                        fifoFlush = 1'b1;
                    end else if ((fifoCount != FULL_COUNT) || fifoPop) begin
                        fifoPush = 1'b1;
                        pc_d     = pc_q + 32'd4;
                    end
                end
                FAULT: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            faultPc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            faultPc_q <= faultPc_d;
        end
    end

    if_fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (fifoPush),
        .push_data_i(pushData),
        .pop_i      (fifoPop),
        .flush_i    (fifoFlush),
        .count_o    (fifoCount),
        .head_o     (fifoHead)
    );

    // Data outputs read as zero whenever nothing is buffered.
    assign imem_addr = pc_q;
    assign out_valid = outValid;
    assign out_instr = outValid ? fifoHead.instr : '0;
    assign out_pc    = outValid ? fifoHead.pc : '0;
    assign fault     = (state_q == FAULT);
    assign fault_pc  = faultPc_q;
    assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_ctrl
// Scoreboard bench for if_fetch_ctrl with a queue-based reference model of
// the fetch sequencer and a big-endian byte-array instruction memory.
// ----------------------------------------------------------------------------
module tb_if_fetch_ctrl;

    localparam int MEM_BYTES = 128;
    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_FAULT   = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entryT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_pc;
    logic        busy;

    byte unsigned mem [MEM_BYTES];
    int           memVersion = 0;

    int nChecks = 0;
    int nFail   = 0;

    // reference model state
    int          mState;
    logic [31:0] mPc;
    logic [31:0] mFaultPc;
    entryT       mQ[$];
    entryT       expQ[$];

    // expectations for the current cycle, published for the monitor
    logic        curValid;
    logic        curBusy;
    logic        curFault;
    logic [31:0] curFaultPc;
    logic [31:0] curAddr;
    entryT       curHead;

    if_fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .MEM_BYTES (MEM_BYTES),
        .FIFO_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .fault         (fault),
        .fault_pc      (fault_pc),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Big-endian word read; anything outside the memory returns a marker.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        int idx;
        if (a < 32'(MEM_BYTES) && a[1:0] == 2'b00) begin
            idx = int'(a);
            return {mem[idx], mem[idx+1], mem[idx+2], mem[idx+3]};
        end
        return 32'hDEAD_BEEF;
    endfunction

    always @(imem_addr or memVersion) imem_rdata = memWord(imem_addr);

    function automatic bit legalPc(input logic [31:0] a);
        return (a % 4 == 0) && (a <= 32'(MEM_BYTES - 4));
    endfunction

    task automatic storeWord(input int a, input logic [31:0] w);
        mem[a]   = w[31:24];
        mem[a+1] = w[23:16];
        mem[a+2] = w[15:8];
        mem[a+3] = w[7:0];
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mState   = M_IDLE;
        mPc      = 32'h0;
        mFaultPc = 32'h0;
        mQ.delete();
        expQ.delete();
    endtask

    // One clock of the reference model: the buffer is a queue of at most two
    // fetched entries; decode takes the head when ready; the sequencer fetches
    // whenever room remains after that.
    task automatic modelStep(input bit st, input bit rv, input logic [31:0] rpc,
                             input bit rdy);
        entryT e;
        curValid   = (mQ.size() > 0);
        curBusy    = (mState == M_RUN);
        curFault   = (mState == M_FAULT);
        curFaultPc = mFaultPc;
        curAddr    = mPc;
        if (mQ.size() > 0) curHead = mQ[0];

        if (mQ.size() > 0 && rdy) expQ.push_back(mQ.pop_front());

        if (rv) begin
            mPc = rpc;
            mQ.delete();
            if (mState == M_FAULT) begin
                if (legalPc(rpc)) mState = M_RUN;
                else              mFaultPc = rpc;
            end
        end else if (mState == M_IDLE) begin
            if (st) mState = M_RUN;
        end else if (mState == M_RUN) begin
            if (!legalPc(mPc)) begin
                mState   = M_FAULT;
                mFaultPc = mPc;
                mQ.delete();
            end else if (mQ.size() < 2) begin
                e.pc    = mPc;
                e.instr = memWord(mPc);
                mQ.push_back(e);
                mPc = mPc + 32'd4;
            end
        end
    endtask

    task automatic applyStimulus(input bit st, input bit rv, input logic [31:0] rpc,
                                 input bit rdy);
        @(negedge clk);
        start          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        modelStep(st, rv, rpc, rdy);
    endtask

    task automatic idleCycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, rdy);
    endtask

    // Reset is asserted mid-cycle so the asynchronous clear is observable
    // before any clock edge.
    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        redirect_valid = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_fault", 32'(fault), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_imem_addr", imem_addr, 32'h0);
        checkOutput("rst_out_instr", out_instr, 32'h0);
        checkOutput("rst_out_pc", out_pc, 32'h0);
        checkOutput("rst_fault_pc", fault_pc, 32'h0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares every cycle against the model's published view and
    // pops the scoreboard whenever the DUT completes a transfer.
    initial begin
        entryT e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1) begin
                checkOutput("busy", 32'(busy), 32'(curBusy));
                checkOutput("fault", 32'(fault), 32'(curFault));
                checkOutput("imem_addr", imem_addr, curAddr);
                checkOutput("out_valid", 32'(out_valid), 32'(curValid));
                if (curFault) checkOutput("fault_pc", fault_pc, curFaultPc);
                if (out_valid && curValid) begin
                    checkOutput("head_pc", out_pc, curHead.pc);
                    checkOutput("head_instr", out_instr, curHead.instr);
                end
                if (out_valid && out_ready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_xfer", 32'h1, 32'h0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("xfer_pc", out_pc, e.pc);
                        checkOutput("xfer_instr", out_instr, e.instr);
                    end
                end
                if (expQ.size() != 0) begin
                    checkOutput("missing_xfer", 32'(expQ.size()), 32'h0);
                    expQ.delete();
                end
            end
        end
    end

    initial begin
        logic [31:0] rpc;
        int          r;
        rst_n          = 1'b0;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;

        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
        storeWord(0,  32'h2002_0001);
        storeWord(4,  32'h2003_0002);
        storeWord(8,  32'h0000_0000);
        storeWord(12, 32'h0103_4020);
        storeWord(16, 32'h2004_0004);
        memVersion++;
        modelReset();

        // in-order fetch with decode always ready
        applyReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        idleCycles(6, 1'b1);

        // decode stalled: buffer fills and PC holds, then redirect flushes
        applyReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        idleCycles(5, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h10, 1'b0);
        idleCycles(4, 1'b1);

        // misaligned redirect faults; legal redirect recovers
        applyStimulus(1'b0, 1'b1, 32'h6, 1'b1);
        idleCycles(3, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b1);
        idleCycles(3, 1'b1);

        // free run off the end of memory
        idleCycles(40, 1'b1);

        // bad redirect while faulted updates fault_pc, good one recovers
        applyStimulus(1'b0, 1'b1, 32'h84, 1'b1);
        idleCycles(2, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h78, 1'b0);
        idleCycles(4, 1'b0);

        // async reset with a full buffer, then idle until start
        applyReset();
        idleCycles(3, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        idleCycles(4, 1'b0);
        applyReset();
        idleCycles(3, 1'b1);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                applyReset();
            end else begin
                r = int'($urandom_range(0, 9));
                if (r < 7)       rpc = {25'h0, 5'($urandom_range(0, 31)), 2'b00};
                else if (r == 7) rpc = {25'h0, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
                else if (r == 8) rpc = 32'h80 + 32'($urandom_range(0, 15)) * 4;
                else             rpc = $urandom;
                applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                              rpc, $urandom_range(0, 3) != 0);
            end
        end
        idleCycles(3, 1'b1);

        @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
